// File: rtl/conv3x3_sequencer_pkg.sv
// Shared constants, state encoding and tap-offset helpers for the 3x3 convolution sequencer.
package conv3x3_sequencer_pkg;

  localparam int unsigned FIL_TAPS = 9;
  localparam int unsigned TAP_AW   = 4;
  localparam logic [TAP_AW-1:0] LAST_TAP = TAP_AW'(FIL_TAPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Window row offset of a row-major tap index (0 = top-left).
  function automatic logic [1:0] tap_row_off(input logic [TAP_AW-1:0] k);
    return 2'(k / 4'd3);
  endfunction

  // Window column offset of a row-major tap index.
  function automatic logic [1:0] tap_col_off(input logic [TAP_AW-1:0] k);
    return 2'(k % 4'd3);
  endfunction

endpackage

// File: rtl/conv3x3_sequencer_if.sv
// Tap load port, control, image RAM read port and result stream of the sequencer.
interface conv3x3_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned ADDR_W = 6
) ();

  logic                     fil_we;
  logic [3:0]               fil_addr;
  logic signed [DATA_W-1:0] fil_data;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     img_rd_en;
  logic [ADDR_W-1:0]        img_addr;
  logic signed [DATA_W-1:0] img_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [ADDR_W-1:0]        out_row;
  logic [ADDR_W-1:0]        out_col;

  // Sequencer side.
  modport slave (
    input  fil_we, fil_addr, fil_data, start, img_rdata, out_ready,
    output busy, done, img_rd_en, img_addr, out_valid, out_data, out_row, out_col
  );

  // Environment side: tap loader, image RAM and downstream consumer.
  modport master (
    output fil_we, fil_addr, fil_data, start, img_rdata, out_ready,
    input  busy, done, img_rd_en, img_addr, out_valid, out_data, out_row, out_col
  );

endinterface

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate; clr restarts the sum with the current product.
module conv_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod_c;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  // Full-precision product, sign-extended and added with wrap-around.
  always_comb begin
    prod_c = a * b;
    acc_d  = (clr ? ACC_W'(0) : acc_q) + ACC_W'(prod_c);
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv3x3_sequencer.sv
// Walks every valid 3x3 window of the image, issues 9 reads per window and streams the MAC result.
module conv3x3_sequencer
  import conv3x3_sequencer_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned ADDR_W = 6
) (
  input logic               clk,
  input logic               rst,
  conv3x3_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        r_q, r_d;
  logic [ADDR_W-1:0]        c_q, c_d;
  logic [TAP_AW-1:0]        k_q, k_d;
  // Tap index and valid flag of the read whose data is on img_rdata this cycle.
  logic [TAP_AW-1:0]        rk_q;
  logic                     rv_q;
  logic                     rd_en_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic signed [DATA_W-1:0] taps_q [FIL_TAPS];

  logic                     hs_c;
  logic                     tap_we_c;
  logic [ADDR_W-1:0]        addr_c;
  logic signed [DATA_W-1:0] tap_sel_c;
  logic signed [ACC_W-1:0]  acc_w;

  // Image address of tap k of the window whose top-left pixel is (r, c).
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] r,
                                                 input logic [ADDR_W-1:0] c,
                                                 input logic [TAP_AW-1:0] k);
    int unsigned row;
    int unsigned col;
    row = 32'(r) + 32'(tap_row_off(k));
    col = 32'(c) + 32'(tap_col_off(k));
    return ADDR_W'(row * IMG_W + col);
  endfunction

  // Next state, window position and fetch counter.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = k_q;
    hs_c     = (state_q == ST_OUT) && bus.out_ready;
    tap_we_c = bus.fil_we && (state_q == ST_IDLE) && (bus.fil_addr <= LAST_TAP);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end
      end
      ST_FETCH: begin
        if (k_q == LAST_TAP) begin
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (hs_c) begin
          k_d     = '0;
          state_d = ((r_q == LAST_ROW) && (c_q == LAST_COL)) ? ST_DONE : ST_FETCH;
          if (c_q < LAST_COL) begin
            c_d = c_q + ADDR_W'(1);
          end else begin
            c_d = '0;
            r_d = r_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    addr_c = pix_addr(r_d, c_d, k_d);
  end

  // Tap read mux for the returning pixel.
  always_comb begin
    tap_sel_c = '0;
    for (int i = 0; i < int'(FIL_TAPS); i++) begin
      if (rk_q == TAP_AW'(i)) tap_sel_c = taps_q[i];
    end
  end

  // State, counters, tap file and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      rk_q    <= '0;
      rv_q    <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(FIL_TAPS); i++) taps_q[i] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      rk_q    <= k_q;
      rv_q    <= rd_en_q;
      rd_en_q <= (state_d == ST_FETCH);
      addr_q  <= (state_d == ST_FETCH) ? addr_c : '0;
      valid_q <= (state_d == ST_OUT);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      for (int i = 0; i < int'(FIL_TAPS); i++) begin
        if (tap_we_c && (bus.fil_addr == TAP_AW'(i))) taps_q[i] <= bus.fil_data;
      end
    end
  end

  // Accumulate one product per returning pixel; tap 0 restarts the sum.
  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (rv_q),
    .clr (rk_q == '0),
    .a   (bus.img_rdata),
    .b   (tap_sel_c),
    .acc (acc_w)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.img_rd_en = rd_en_q;
  assign bus.img_addr  = addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = acc_w;
  assign bus.out_row   = r_q;
  assign bus.out_col   = c_q;

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Directed bench: image RAM model, convolution reference model and per-cycle output checker.
module tb_conv3x3_sequencer;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned ADDR_W = 6;
  localparam int NPIX = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    int row;
    int col;
    int data;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv3x3_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

  conv3x3_sequencer #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .DATA_W (DATA_W), .ACC_W (ACC_W), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [DATA_W-1:0] mem [IMG_W*IMG_H];
  int   m_tap [9];
  res_t exp_q [$];
  int   addr_q [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int first_rise = -1;
  int first_data, first_row, first_col;
  int last_data, last_row, last_col;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read image RAM; junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (bus.img_rd_en) bus.img_rdata <= mem[bus.img_addr];
    else bus.img_rdata <= 8'sh55;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Expected read addresses and results of a full pass from the current image and taps.
  task automatic build_expect();
    int sum;
    int a;
    logic signed [ACC_W-1:0] w;
    exp_q.delete();
    addr_q.delete();
    for (int r = 0; r < int'(IMG_H) - 2; r++) begin
      for (int c = 0; c < int'(IMG_W) - 2; c++) begin
        sum = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            a = (r + i) * int'(IMG_W) + c + j;
            addr_q.push_back(a);
            sum += int'(mem[a]) * m_tap[i*3+j];
          end
        end
        w = ACC_W'(sum);
        exp_q.push_back('{r, c, int'(w)});
      end
    end
  endtask

  // Per-cycle checker: read addresses, result stream, backpressure hold, done placement.
  bit prev_valid = 1'b0;
  bit prev_hs = 1'b0;
  bit exp_done = 1'b0;
  bit exp_fetch = 1'b0;
  int since_rd = 99;
  int p_data, p_row, p_col;
  res_t e;
  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit hs = bus.out_valid && bus.out_ready;
      if (bus.img_rd_en) since_rd = 0;
      else since_rd++;
      if (bus.img_rd_en) begin
        if (addr_q.size() == 0) fail("extra_read");
        else check("img_addr", bus.img_addr, addr_q.pop_front());
        check("rd_while_valid", bus.out_valid, 0);
      end
      if (bus.img_rd_en || bus.out_valid || bus.done) check("busy", bus.busy, 1);
      if (exp_fetch) begin
        check("valid_fall", bus.out_valid, 0);
        check("resume_fetch", bus.img_rd_en, 1);
      end
      if (exp_done) begin
        check("done_after_last", bus.done, 1);
        check("valid_in_done", bus.out_valid, 0);
      end else if (bus.done) begin
        fail("spurious_done");
      end
      if (bus.done) done_cnt++;
      if (bus.out_valid) begin
        if (!prev_valid) begin
          check("out_after_drain", since_rd, 2);
          if (first_rise < 0) first_rise = cyc - t0 + 1;
        end else if (!prev_hs) begin
          check("hold_data", bus.out_data, p_data);
          check("hold_row", bus.out_row, p_row);
          check("hold_col", bus.out_col, p_col);
        end
      end
      exp_fetch = 1'b0;
      exp_done  = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          fail("extra_result");
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_row", bus.out_row, e.row);
          check("out_col", bus.out_col, e.col);
          if (hs_cnt == 0) begin
            first_data = bus.out_data;
            first_row  = bus.out_row;
            first_col  = bus.out_col;
          end
          last_data = bus.out_data;
          last_row  = bus.out_row;
          last_col  = bus.out_col;
          hs_cnt++;
          if (exp_q.size() == 0) exp_done = 1'b1;
          else exp_fetch = 1'b1;
        end
      end
      prev_valid = bus.out_valid;
      prev_hs    = hs;
      p_data     = bus.out_data;
      p_row      = bus.out_row;
      p_col      = bus.out_col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input int a, input int d);
    bus.fil_we   = 1'b1;
    bus.fil_addr = 4'(a);
    bus.fil_data = DATA_W'(d);
    tick();
    bus.fil_we = 1'b0;
  endtask

  task automatic load_taps(input int v0, input int vall);
    for (int k = 0; k < 9; k++) begin
      m_tap[k] = (k == 4) ? v0 : vall;
      write_tap(k, m_tap[k]);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_rd_en"}, bus.img_rd_en, 0);
    check({tag, "_addr"}, bus.img_addr, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_row"}, bus.out_row, 0);
    check({tag, "_col"}, bus.out_col, 0);
  endtask

  // One full pass: optional backpressure at the first result, stray starts, a tap write while busy.
  task automatic run_pass(input int stall, input bit stray_start, input bit busy_wr);
    int  stall_cnt;
    int  done0;
    bit  got_done;
    stall_cnt  = 0;
    got_done   = 1'b0;
    done0      = done_cnt;
    hs_cnt     = 0;
    first_rise = -1;
    bus.out_ready = (stall == 0);
    bus.start = 1'b1;
    tick();
    t0 = cyc;
    for (int rel = 1; rel < 800; rel++) begin
      if (bus.done) got_done = 1'b1;
      bus.start = stray_start && (rel == 3 || (bus.out_valid && hs_cnt == 0) || bus.done);
      bus.fil_we = busy_wr && (rel == 5);
      bus.fil_addr = 4'd4;
      bus.fil_data = 8'sd5;
      if (hs_cnt > 0) begin
        bus.out_ready = 1'b1;
      end else if (bus.out_valid && stall > 0) begin
        bus.out_ready = (stall_cnt >= stall);
        stall_cnt++;
      end
      tick();
      if (got_done) break;
    end
    bus.start = 1'b0;
    bus.fil_we = 1'b0;
    bus.out_ready = 1'b1;
    if (!got_done) fail("pass_timeout");
    repeat (3) tick();
    check("idle_busy", bus.busy, 0);
    check("results_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    check("result_count", hs_cnt, NPIX);
    check("done_pulses", done_cnt - done0, 1);
    check("first_out_cycle", first_rise, 11);
  endtask

  initial begin
    bus.fil_we = 1'b0;
    bus.fil_addr = '0;
    bus.fil_data = '0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) m_tap[k] = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outputs_zero("reset");
    rst = 1'b1;
    tick();
    outputs_zero("after_reset");
    chk_en = 1'b1;

    // Identity filter over pixel = address; stall first result, tap write while busy.
    load_taps(1, 0);
    write_tap(9, 7);
    for (int a = 0; a < int'(IMG_W*IMG_H); a++) mem[a] = DATA_W'(a);
    build_expect();
    check("model_first", exp_q[0].data, 9);
    check("model_last", exp_q[NPIX-1].data, 54);
    run_pass(5, 1'b0, 1'b1);
    check("id_first_data", first_data, 9);
    check("id_first_row", first_row, 0);
    check("id_first_col", first_col, 0);
    check("id_last_data", last_data, 54);
    check("id_last_row", last_row, 5);
    check("id_last_col", last_col, 5);

    // Same pass with start pulsed in FETCH, OUT and DONE.
    build_expect();
    run_pass(0, 1'b1, 1'b0);
    check("stray_first_data", first_data, 9);
    check("stray_last_data", last_data, 54);

    // All ones.
    load_taps(1, 1);
    for (int a = 0; a < int'(IMG_W*IMG_H); a++) mem[a] = 8'sd1;
    build_expect();
    check("model_ones", exp_q[0].data, 9);
    run_pass(0, 1'b0, 1'b0);
    check("ones_first", first_data, 9);
    check("ones_last", last_data, 9);

    // Worst-case magnitude.
    load_taps(-128, -128);
    for (int a = 0; a < int'(IMG_W*IMG_H); a++) mem[a] = -8'sd128;
    build_expect();
    check("model_max", exp_q[0].data, 147456);
    run_pass(0, 1'b0, 1'b0);
    check("max_first", first_data, 147456);
    check("max_last", last_data, 147456);

    // Abort during the 4th FETCH cycle.
    build_expect();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    outputs_zero("abort");
    repeat (2) begin
      tick();
      check("abort_done", bus.done, 0);
    end
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    prev_valid = 1'b0;
    prev_hs = 1'b0;
    since_rd = 99;
    for (int k = 0; k < 9; k++) m_tap[k] = 0;
    chk_en = 1'b1;
    repeat (3) begin
      tick();
      check("post_abort_busy", bus.busy, 0);
    end

    // Taps were cleared by reset: every result is zero.
    build_expect();
    check("model_zero", exp_q[NPIX-1].data, 0);
    run_pass(0, 1'b0, 1'b0);
    check("zero_first", first_data, 0);
    check("zero_last", last_data, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv3x3_sequencer.md
Name: conv3x3_sequencer

Overview:
Controller plus MAC datapath that runs a 3x3 valid convolution over an IMG_W x IMG_H image held in an external synchronous-read memory. It holds the 9 filter taps in a register file written through a load port. On start it walks every output position, issues the 9 window reads, and accumulates one product per cycle. Each result goes out on a valid/ready stream, and a done pulse follows the final pixel. It sits between the image RAM and the downstream pooling/activation stage.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
DATA_W, 8, signed pixel and tap width
ACC_W, 20, signed accumulator/result width (>= 2*DATA_W+4)
ADDR_W, 6, image address width (>= clog2(IMG_W*IMG_H))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
fil_we  in  1  filter tap write strobe
fil_addr  in  4  tap index 0..8, row-major (0 = top-left)
fil_data  in  DATA_W  signed tap value
start  in  1  begin a full-image pass (single-cycle pulse)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result handshake
img_rd_en  out  1  image read request
img_addr  out  ADDR_W  row*IMG_W+col of requested pixel
img_rdata  in  DATA_W  signed pixel, valid the cycle after img_rd_en
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  signed convolution sum
out_row  out  ADDR_W  output row 0..IMG_H-3
out_col  out  ADDR_W  output column 0..IMG_W-3

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Taps, accumulator, row/col counters and tap counter 0. Reset mid-pass aborts it with no done pulse and clears the taps.
- Tap writes: accepted only in IDLE with fil_addr<=8. fil_addr 9..15 is ignored. Writes while busy are ignored. Taps are stable for the whole pass.
- States: IDLE, FETCH, DRAIN, OUT, DONE.
- IDLE: start=1 -> FETCH next cycle, with r=c=k=0. start is ignored in every other state.
- FETCH, 9 cycles, k=0..8: img_rd_en=1 and img_addr=(r+k/3)*IMG_W+(c+k%3).
  - A pipelined k_d register tracks the returning tap.
  - On the cycle after each read: acc <= (k_d==0 ? 0 : acc) + img_rdata*tap[k_d].
  - After k=8 -> DRAIN.
- DRAIN, 1 cycle: accumulate the tap-8 product. img_rd_en=0. -> OUT.
- OUT: out_valid=1; out_data=acc, out_row=r, out_col=c, all held stable until out_ready=1. No reads are issued.
  - On handshake: if c<IMG_W-3 then c++; else c=0 and r++.
  - After the handshake of the last pixel (r=IMG_H-3, c=IMG_W-3) -> DONE; otherwise -> FETCH.
- DONE: done=1 and busy=1 for one cycle, then -> IDLE. out_valid is 0.
- Latency: with start sampled at edge 0, FETCH covers cycles 1-9, DRAIN cycle 10, first out_valid cycle 11. Each further pixel costs 11 cycles plus the backpressure stall.
- Arithmetic: signed DATA_W x DATA_W product, sign-extended to ACC_W. Wrap-around on overflow, no saturation. ACC_W=20 covers the worst case 9*(-128*-128)=147456.
- out_valid falls the cycle after the handshake.

Decomposition:
- Shared include conv_defs.vh holds:
  - FIL_TAPS=9
  - state encodings (IDLE=0, FETCH=1, DRAIN=2, OUT=3, DONE=4)
  - tap row/column offset constants
- One sub-module, conv_mac: registered signed multiply-accumulate with clear input. Ports: clk, rst, en, clr, a, b, acc.
- Counters, tap register file and FSM stay in conv3x3_sequencer.

Test Plan:
- Identity filter (tap4=1, others 0), 8x8 image with pixel = address (0..63), start -> 36 results. First result is out_data=9 at row 0, col 0 on cycle 11. Last result is out_data=54 at row 5, col 5. One done pulse after it.
- All-ones taps, all-ones image -> every out_data=9. Then taps all -128 and image all -128 -> every out_data=147456, no overflow.
- Hold out_ready=0 for 5 cycles at the first result -> out_valid, out_data, out_row and out_col stay constant, with img_rd_en=0 throughout. Raising out_ready gives one handshake, then FETCH resumes.
- Write tap4=5 while busy, and fil_addr=9 in IDLE -> no tap changes. Identity pass still gives 9 for the first result.
- Assert rst=0 during the 4th FETCH cycle -> all outputs 0 immediately, state IDLE, no done. A subsequent start without reloading taps gives all 36 results = 0.
- Pulse start in FETCH, OUT and DONE -> no restart. The pixel sequence and count (36) are unchanged.
